// File: rtl/axi_rd_arb_pkg.sv
// Shared AXI read-channel widths, arbiter state encoding and the AR payload bundle
// used by the two-master ROM read arbiter.
package axi_rd_arb_pkg;

  localparam int AXI_ID_WIDTH     = 4;
  localparam int AXI_ADDR_WIDTH   = 32;
  localparam int AXI_LEN_WIDTH    = 8;
  localparam int AXI_SIZE_WIDTH   = 3;
  localparam int AXI_BURST_WIDTH  = 2;
  localparam int AXI_LOCK_WIDTH   = 1;
  localparam int AXI_CACHE_WIDTH  = 4;
  localparam int AXI_PROT_WIDTH   = 3;
  localparam int AXI_QOS_WIDTH    = 4;
  localparam int AXI_REGION_WIDTH = 4;
  localparam int AXI_DATA_WIDTH   = 32;
  localparam int AXI_RESP_WIDTH   = 2;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_e;

  // Field order matches the AR port order so a plain concatenation packs it.
  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0]     id;
    logic [AXI_ADDR_WIDTH-1:0]   addr;
    logic [AXI_LEN_WIDTH-1:0]    len;
    logic [AXI_SIZE_WIDTH-1:0]   size;
    logic [AXI_BURST_WIDTH-1:0]  burst;
    logic [AXI_LOCK_WIDTH-1:0]   lock;
    logic [AXI_CACHE_WIDTH-1:0]  cache;
    logic [AXI_PROT_WIDTH-1:0]   prot;
    logic [AXI_QOS_WIDTH-1:0]    qos;
    logic [AXI_REGION_WIDTH-1:0] region;
  } ar_pay_t;

endpackage

// File: rtl/axi_rd_arb_rr.sv
// Two-way request picker: a lone requester wins; on a tie the pointed-to master
// wins in round-robin mode, master 0 wins in fixed-priority mode.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio_ptr,
  input  logic       rr_en,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (rr_en && prio_ptr) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/axi_rd_arb.sv
// Shares the instruction ROM AXI read port between the IFU (master 0) and a second
// read master; one transaction at a time, grant locked from AR issue to final R beat.
module axi_rd_arb
  import axi_rd_arb_pkg::*;
#(
  parameter logic RR_EN = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  // Handshakes: a transfer occurs on a rising edge where valid && ready are both high;
  // no valid output here depends on the ready it is paired with.
  input  logic                        m0_arvalid,
  output logic                        m0_arready,
  input  logic [AXI_ID_WIDTH-1:0]     m0_arid,
  input  logic [AXI_ADDR_WIDTH-1:0]   m0_araddr,
  input  logic [AXI_LEN_WIDTH-1:0]    m0_arlen,
  input  logic [AXI_SIZE_WIDTH-1:0]   m0_arsize,
  input  logic [AXI_BURST_WIDTH-1:0]  m0_arburst,
  input  logic [AXI_LOCK_WIDTH-1:0]   m0_arlock,
  input  logic [AXI_CACHE_WIDTH-1:0]  m0_arcache,
  input  logic [AXI_PROT_WIDTH-1:0]   m0_arprot,
  input  logic [AXI_QOS_WIDTH-1:0]    m0_arqos,
  input  logic [AXI_REGION_WIDTH-1:0] m0_arregion,
  output logic                        m0_rvalid,
  input  logic                        m0_rready,
  output logic [AXI_ID_WIDTH-1:0]     m0_rid,
  output logic [AXI_DATA_WIDTH-1:0]   m0_rdata,
  output logic [AXI_RESP_WIDTH-1:0]   m0_rresp,
  output logic                        m0_rlast,
  input  logic                        m1_arvalid,
  output logic                        m1_arready,
  input  logic [AXI_ID_WIDTH-1:0]     m1_arid,
  input  logic [AXI_ADDR_WIDTH-1:0]   m1_araddr,
  input  logic [AXI_LEN_WIDTH-1:0]    m1_arlen,
  input  logic [AXI_SIZE_WIDTH-1:0]   m1_arsize,
  input  logic [AXI_BURST_WIDTH-1:0]  m1_arburst,
  input  logic [AXI_LOCK_WIDTH-1:0]   m1_arlock,
  input  logic [AXI_CACHE_WIDTH-1:0]  m1_arcache,
  input  logic [AXI_PROT_WIDTH-1:0]   m1_arprot,
  input  logic [AXI_QOS_WIDTH-1:0]    m1_arqos,
  input  logic [AXI_REGION_WIDTH-1:0] m1_arregion,
  output logic                        m1_rvalid,
  input  logic                        m1_rready,
  output logic [AXI_ID_WIDTH-1:0]     m1_rid,
  output logic [AXI_DATA_WIDTH-1:0]   m1_rdata,
  output logic [AXI_RESP_WIDTH-1:0]   m1_rresp,
  output logic                        m1_rlast,
  output logic                        s_arvalid,
  input  logic                        s_arready,
  output logic [AXI_ID_WIDTH-1:0]     s_arid,
  output logic [AXI_ADDR_WIDTH-1:0]   s_araddr,
  output logic [AXI_LEN_WIDTH-1:0]    s_arlen,
  output logic [AXI_SIZE_WIDTH-1:0]   s_arsize,
  output logic [AXI_BURST_WIDTH-1:0]  s_arburst,
  output logic [AXI_LOCK_WIDTH-1:0]   s_arlock,
  output logic [AXI_CACHE_WIDTH-1:0]  s_arcache,
  output logic [AXI_PROT_WIDTH-1:0]   s_arprot,
  output logic [AXI_QOS_WIDTH-1:0]    s_arqos,
  output logic [AXI_REGION_WIDTH-1:0] s_arregion,
  input  logic                        s_rvalid,
  output logic                        s_rready,
  input  logic [AXI_ID_WIDTH-1:0]     s_rid,
  input  logic [AXI_DATA_WIDTH-1:0]   s_rdata,
  input  logic [AXI_RESP_WIDTH-1:0]   s_rresp,
  input  logic                        s_rlast,
  output logic                        grant_id,
  output logic                        err_last,
  output arb_state_e                  dbg_state
);

  arb_state_e               state, state_nxt;
  logic                     grant_nxt, prio_ptr, prio_nxt, err_nxt;
  logic [AXI_LEN_WIDTH-1:0] beat_rem, beat_nxt;
  logic [1:0]               gnt;
  ar_pay_t                  m0_pay, m1_pay, sel_pay, s_pay;
  logic                     in_addr, in_data, route0, route1;

  rr_arb2 u_pick (
    .req      ({m1_arvalid, m0_arvalid}),
    .prio_ptr (prio_ptr),
    .rr_en    (RR_EN),
    .gnt      (gnt)
  );

  assign m0_pay  = {m0_arid, m0_araddr, m0_arlen, m0_arsize, m0_arburst, m0_arlock,
                    m0_arcache, m0_arprot, m0_arqos, m0_arregion};
  assign m1_pay  = {m1_arid, m1_araddr, m1_arlen, m1_arsize, m1_arburst, m1_arlock,
                    m1_arcache, m1_arprot, m1_arqos, m1_arregion};
  assign sel_pay = grant_id ? m1_pay : m0_pay;

  assign in_addr = (state == ARB_ADDR);
  assign in_data = (state == ARB_DATA);
  assign route0  = in_data && !grant_id;
  assign route1  = in_data && grant_id;

  // AR side: payload is zeroed outside ADDR so idle outputs stay quiet.
  assign s_arvalid = in_addr;
  assign s_pay     = in_addr ? sel_pay : '0;
  assign {s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arlock,
          s_arcache, s_arprot, s_arqos, s_arregion} = s_pay;
  assign m0_arready = in_addr && !grant_id && s_arready;
  assign m1_arready = in_addr && grant_id && s_arready;

  // R side: only the granted master sees beats; the other gets zeros.
  assign s_rready  = in_data && (grant_id ? m1_rready : m0_rready);
  assign m0_rvalid = route0 && s_rvalid;
  assign m1_rvalid = route1 && s_rvalid;
  assign {m0_rid, m0_rdata, m0_rresp, m0_rlast} = route0 ? {s_rid, s_rdata, s_rresp, s_rlast} : '0;
  assign {m1_rid, m1_rdata, m1_rresp, m1_rlast} = route1 ? {s_rid, s_rdata, s_rresp, s_rlast} : '0;

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB_IDLE;
      grant_id <= 1'b0;
      prio_ptr <= 1'b0;
      beat_rem <= '0;
      err_last <= 1'b0;
    end else begin
      state    <= state_nxt;
      grant_id <= grant_nxt;
      prio_ptr <= prio_nxt;
      beat_rem <= beat_nxt;
      err_last <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_id;
    prio_nxt  = prio_ptr;
    beat_nxt  = beat_rem;
    err_nxt   = err_last;
    case (state)
      ARB_IDLE: begin
        if (|gnt) begin
          state_nxt = ARB_ADDR;
          grant_nxt = gnt[1];
        end
      end
      ARB_ADDR: begin
        if (s_arready) begin
          beat_nxt  = sel_pay.len;
          state_nxt = ARB_DATA;
        end
      end
      ARB_DATA: begin
        if (s_rvalid && s_rready) begin
          // beat_rem saturates at zero; rlast must coincide exactly with zero.
          if (beat_rem != '0) beat_nxt = beat_rem - 1'b1;
          if (s_rlast != (beat_rem == '0)) err_nxt = 1'b1;
          if (s_rlast) begin
            state_nxt = ARB_IDLE;
            if (RR_EN) prio_nxt = ~grant_id;
          end
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_rd_arb.sv
// Randomized bench for axi_rd_arb: transaction-level arbitration/routing model with a
// scoreboard of expected R data, plus a fixed-priority instance for starvation checks.
`timescale 1ns/1ps
module tb_axi_rd_arb;
  import axi_rd_arb_pkg::*;

  localparam int IW = AXI_ID_WIDTH;
  localparam int AW = AXI_ADDR_WIDTH;
  localparam int LW = AXI_LEN_WIDTH;
  localparam int DW = AXI_DATA_WIDTH;
  localparam int RW = AXI_RESP_WIDTH;
  typedef enum int {PH_IDLE, PH_ADDR, PH_DATA} ph_e;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // master stimulus, indexed by master number
  logic [IW-1:0] m_id[2];
  logic [AW-1:0] m_addr[2];
  logic [LW-1:0] m_len[2];
  logic [AXI_SIZE_WIDTH-1:0]   m_size[2];
  logic [AXI_BURST_WIDTH-1:0]  m_burst[2];
  logic [AXI_LOCK_WIDTH-1:0]   m_lock[2];
  logic [AXI_CACHE_WIDTH-1:0]  m_cache[2];
  logic [AXI_PROT_WIDTH-1:0]   m_prot[2];
  logic [AXI_QOS_WIDTH-1:0]    m_qos[2];
  logic [AXI_REGION_WIDTH-1:0] m_region[2];
  logic m_arvalid[2], m_rready[2];
  logic s_arready, s_rvalid, s_rlast;
  logic [IW-1:0] s_rid;
  logic [DW-1:0] s_rdata;
  logic [RW-1:0] s_rresp;

  // main DUT outputs
  logic m0_arready, m1_arready, m0_rvalid, m1_rvalid, m0_rlast, m1_rlast;
  logic [IW-1:0] m0_rid, m1_rid, s_arid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [RW-1:0] m0_rresp, m1_rresp;
  logic s_arvalid, s_rready, grant_id, err_last;
  logic [AW-1:0] s_araddr;
  logic [LW-1:0] s_arlen;
  logic [AXI_SIZE_WIDTH-1:0]   s_arsize;
  logic [AXI_BURST_WIDTH-1:0]  s_arburst;
  logic [AXI_LOCK_WIDTH-1:0]   s_arlock;
  logic [AXI_CACHE_WIDTH-1:0]  s_arcache;
  logic [AXI_PROT_WIDTH-1:0]   s_arprot;
  logic [AXI_QOS_WIDTH-1:0]    s_arqos;
  logic [AXI_REGION_WIDTH-1:0] s_arregion;
  arb_state_e dut_state;

  // fixed-priority DUT: fp_go drives every valid/ready/rlast input
  logic fp_go;
  logic fp_m0_arready, fp_m1_arready, fp_m0_rvalid, fp_m1_rvalid, fp_m0_rlast, fp_m1_rlast;
  logic [IW-1:0] fp_m0_rid, fp_m1_rid, fp_s_arid;
  logic [DW-1:0] fp_m0_rdata, fp_m1_rdata;
  logic [RW-1:0] fp_m0_rresp, fp_m1_rresp;
  logic fp_s_arvalid, fp_s_rready, fp_grant_id, fp_err_last;
  logic [AW-1:0] fp_s_araddr;
  logic [LW-1:0] fp_s_arlen;
  logic [AXI_SIZE_WIDTH-1:0]   fp_s_arsize;
  logic [AXI_BURST_WIDTH-1:0]  fp_s_arburst;
  logic [AXI_LOCK_WIDTH-1:0]   fp_s_arlock;
  logic [AXI_CACHE_WIDTH-1:0]  fp_s_arcache;
  logic [AXI_PROT_WIDTH-1:0]   fp_s_arprot;
  logic [AXI_QOS_WIDTH-1:0]    fp_s_arqos;
  logic [AXI_REGION_WIDTH-1:0] fp_s_arregion;
  arb_state_e fp_state;

  axi_rd_arb #(.RR_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .m0_arvalid(m_arvalid[0]), .m0_arready(m0_arready), .m0_arid(m_id[0]), .m0_araddr(m_addr[0]),
    .m0_arlen(m_len[0]), .m0_arsize(m_size[0]), .m0_arburst(m_burst[0]), .m0_arlock(m_lock[0]),
    .m0_arcache(m_cache[0]), .m0_arprot(m_prot[0]), .m0_arqos(m_qos[0]), .m0_arregion(m_region[0]),
    .m0_rvalid(m0_rvalid), .m0_rready(m_rready[0]), .m0_rid(m0_rid), .m0_rdata(m0_rdata),
    .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
    .m1_arvalid(m_arvalid[1]), .m1_arready(m1_arready), .m1_arid(m_id[1]), .m1_araddr(m_addr[1]),
    .m1_arlen(m_len[1]), .m1_arsize(m_size[1]), .m1_arburst(m_burst[1]), .m1_arlock(m_lock[1]),
    .m1_arcache(m_cache[1]), .m1_arprot(m_prot[1]), .m1_arqos(m_qos[1]), .m1_arregion(m_region[1]),
    .m1_rvalid(m1_rvalid), .m1_rready(m_rready[1]), .m1_rid(m1_rid), .m1_rdata(m1_rdata),
    .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid), .s_araddr(s_araddr),
    .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arlock(s_arlock),
    .s_arcache(s_arcache), .s_arprot(s_arprot), .s_arqos(s_arqos), .s_arregion(s_arregion),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast),
    .grant_id(grant_id), .err_last(err_last), .dbg_state(dut_state)
  );

  axi_rd_arb #(.RR_EN(1'b0)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .m0_arvalid(fp_go), .m0_arready(fp_m0_arready), .m0_arid(m_id[0]), .m0_araddr(m_addr[0]),
    .m0_arlen(m_len[0]), .m0_arsize(m_size[0]), .m0_arburst(m_burst[0]), .m0_arlock(m_lock[0]),
    .m0_arcache(m_cache[0]), .m0_arprot(m_prot[0]), .m0_arqos(m_qos[0]), .m0_arregion(m_region[0]),
    .m0_rvalid(fp_m0_rvalid), .m0_rready(fp_go), .m0_rid(fp_m0_rid), .m0_rdata(fp_m0_rdata),
    .m0_rresp(fp_m0_rresp), .m0_rlast(fp_m0_rlast),
    .m1_arvalid(fp_go), .m1_arready(fp_m1_arready), .m1_arid(m_id[1]), .m1_araddr(m_addr[1]),
    .m1_arlen(m_len[1]), .m1_arsize(m_size[1]), .m1_arburst(m_burst[1]), .m1_arlock(m_lock[1]),
    .m1_arcache(m_cache[1]), .m1_arprot(m_prot[1]), .m1_arqos(m_qos[1]), .m1_arregion(m_region[1]),
    .m1_rvalid(fp_m1_rvalid), .m1_rready(fp_go), .m1_rid(fp_m1_rid), .m1_rdata(fp_m1_rdata),
    .m1_rresp(fp_m1_rresp), .m1_rlast(fp_m1_rlast),
    .s_arvalid(fp_s_arvalid), .s_arready(fp_go), .s_arid(fp_s_arid), .s_araddr(fp_s_araddr),
    .s_arlen(fp_s_arlen), .s_arsize(fp_s_arsize), .s_arburst(fp_s_arburst), .s_arlock(fp_s_arlock),
    .s_arcache(fp_s_arcache), .s_arprot(fp_s_arprot), .s_arqos(fp_s_arqos), .s_arregion(fp_s_arregion),
    .s_rvalid(fp_go), .s_rready(fp_s_rready), .s_rid(s_rid), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(fp_go),
    .grant_id(fp_grant_id), .err_last(fp_err_last), .dbg_state(fp_state)
  );

  // reference model / scoreboard state
  int n_chk = 0, n_bad = 0, cyc = 0;
  ph_e ph;
  logic exp_g, prio, exp_err, inj_early, toggle_rr, force_sl;
  logic req_v[2];
  int reqs_left[2], beats_to[2];
  logic [DW-1:0] exp_q[$];
  logic gseq[$];
  logic [IW-1:0] exp_id;
  int exp_len, beat_k;
  // slave model
  logic sl_busy;
  logic [AW-1:0] sl_addr;
  logic [IW-1:0] sl_id;
  int sl_beat, sl_last_at;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rd_data(input logic [AW-1:0] a, input int b);
    return (a ^ 32'h5a5a_0000) + 32'(b) * 32'h0101_0004;
  endfunction

  task automatic new_req(input int n, input int len);
    m_id[n]     = IW'($urandom);
    m_addr[n]   = $urandom & 32'hffff_fff0;
    m_len[n]    = LW'(len);
    m_size[n]   = AXI_SIZE_WIDTH'($urandom);
    m_burst[n]  = AXI_BURST_WIDTH'($urandom);
    m_lock[n]   = AXI_LOCK_WIDTH'($urandom);
    m_cache[n]  = AXI_CACHE_WIDTH'($urandom);
    m_prot[n]   = AXI_PROT_WIDTH'($urandom);
    m_qos[n]    = AXI_QOS_WIDTH'($urandom);
    m_region[n] = AXI_REGION_WIDTH'($urandom);
    req_v[n]    = 1'b1;
  endtask

  task automatic model_reset();
    ph = PH_IDLE; prio = 1'b0; exp_err = 1'b0; inj_early = 1'b0;
    toggle_rr = 1'b0; force_sl = 1'b0; sl_busy = 1'b0; sl_beat = 0; sl_last_at = 0;
    exp_q.delete(); gseq.delete();
    for (int n = 0; n < 2; n++) begin
      req_v[n] = 1'b0; reqs_left[n] = 0; beats_to[n] = 0;
      m_arvalid[n] = 1'b0; m_rready[n] = 1'b0;
    end
    s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_valids", {s_arvalid, s_rready, m0_arready, m1_arready, m0_rvalid, m1_rvalid}, 0);
    chk("rst_grant_err", {grant_id, err_last}, 0);
    chk("rst_state", dut_state, ARB_IDLE);
    chk("rst_payload", {m0_rdata, m1_rdata, s_araddr, m0_rlast, m1_rlast}, 0);
  endtask

  // Asserts reset with current inputs still applied, checks, then releases at posedge+1.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic sample();
    chk("err_last", err_last, exp_err);
    case (ph)
      PH_IDLE: begin
        chk("idle_s_arvalid", s_arvalid, 0);
        chk("idle_readies", {m1_arready, m0_arready, s_rready}, 0);
        chk("idle_rvalid", {m1_rvalid, m0_rvalid}, 0);
        if (req_v[0] || req_v[1]) begin
          exp_g = (req_v[0] && req_v[1]) ? prio : req_v[1];
          ph = PH_ADDR;
        end
      end
      PH_ADDR: begin
        chk("addr_s_arvalid", s_arvalid, 1);
        chk("grant_id", grant_id, exp_g);
        chk("s_ar_payload",
            {s_arid, s_araddr, s_arlen, s_arsize, s_arburst, s_arlock, s_arcache, s_arprot, s_arqos, s_arregion},
            {m_id[exp_g], m_addr[exp_g], m_len[exp_g], m_size[exp_g], m_burst[exp_g], m_lock[exp_g],
             m_cache[exp_g], m_prot[exp_g], m_qos[exp_g], m_region[exp_g]});
        chk("arready_route", {m1_arready, m0_arready}, s_arready ? (2'b01 << exp_g) : 2'b00);
        if (s_arready) begin
          for (int i = 0; i <= int'(m_len[exp_g]); i++) exp_q.push_back(rd_data(m_addr[exp_g], i));
          exp_id = m_id[exp_g]; exp_len = int'(m_len[exp_g]); beat_k = 0;
          gseq.push_back(exp_g);
          req_v[exp_g] = 1'b0;
          sl_busy = 1'b1; sl_addr = s_araddr; sl_id = s_arid; sl_beat = 0;
          sl_last_at = inj_early ? 1 : int'(s_arlen);
          inj_early = 1'b0;
          ph = PH_DATA;
        end
      end
      default: begin
        chk("data_s_arvalid", s_arvalid, 0);
        chk("data_arready", {m1_arready, m0_arready}, 0);
        chk("rvalid_route", {m1_rvalid, m0_rvalid}, s_rvalid ? (2'b01 << exp_g) : 2'b00);
        chk("s_rready", s_rready, m_rready[exp_g]);
        if (s_rvalid && s_rready) begin
          if (exp_q.size() == 0) chk("rdata_extra_beat", 1, 0);
          else chk("rdata", exp_g ? m1_rdata : m0_rdata, exp_q.pop_front());
          chk("rid", exp_g ? m1_rid : m0_rid, exp_id);
          chk("rlast_route", exp_g ? m1_rlast : m0_rlast, s_rlast);
          if ((s_rlast && beat_k != exp_len) || (!s_rlast && beat_k >= exp_len)) exp_err = 1'b1;
          beats_to[exp_g]++; beat_k++; sl_beat++;
          if (s_rlast) begin
            exp_q.delete();
            prio = ~exp_g;
            sl_busy = 1'b0;
            ph = PH_IDLE;
          end
        end
      end
    endcase
  endtask

  // driver: one cycle of stimulus, then sample, then advance to posedge+1
  task automatic step();
    for (int n = 0; n < 2; n++) begin
      if (!req_v[n] && reqs_left[n] > 0 && $urandom_range(0, 99) < 40) begin
        new_req(n, $urandom_range(0, 3));
        reqs_left[n]--;
      end
      m_rready[n] = toggle_rr ? cyc[0] : ($urandom_range(0, 99) < 70);
      m_arvalid[n] = req_v[n];
    end
    s_arready = !sl_busy && (force_sl || $urandom_range(0, 99) < 60);
    s_rvalid  = sl_busy && (force_sl || $urandom_range(0, 99) < 70);
    s_rid     = sl_id;
    s_rdata   = sl_busy ? rd_data(sl_addr, sl_beat) : '0;
    s_rresp   = RW'(sl_beat);
    s_rlast   = sl_busy && (sl_beat == sl_last_at);
    #1;
    sample();
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic run_idle(input int budget);
    int c = 0;
    do begin
      step();
      c++;
    end while (!(ph == PH_IDLE && !req_v[0] && !req_v[1] && reqs_left[0] == 0 && reqs_left[1] == 0)
               && c < budget);
    chk("run_within_budget", c < budget, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fp_hs, n0, c;
    logic [3:0] gv;
    rst_n = 1'b1; fp_go = 1'b0; sl_id = '0; sl_addr = '0;
    s_rid = '0; s_rdata = '0; s_rresp = '0;
    for (int n = 0; n < 2; n++) new_req(n, 0);
    model_reset();
    #2;
    do_reset();

    // fixed priority: both request forever, m1 never gets in
    fp_go = 1'b1; fp_hs = 0;
    for (int i = 0; i < 39; i++) begin
      #1;
      chk("fp_m1_arready", fp_m1_arready, 0);
      chk("fp_m1_rvalid", fp_m1_rvalid, 0);
      chk("fp_grant_id", fp_grant_id, 0);
      if (fp_m0_arready) fp_hs++;
      @(posedge clk); #1;
    end
    chk("fp_m0_grants", fp_hs, 13);
    fp_go = 1'b0;
    do_reset();

    // single m0 read at 0x100, arlen=0
    new_req(0, 0); m_addr[0] = 32'h100;
    run_idle(50);
    chk("t1_grants", gseq.size(), 1);
    chk("t1_beats", {beats_to[1][7:0], beats_to[0][7:0]}, 16'h0001);

    // simultaneous pairs after reset: grant order 0,1,0,1
    do_reset();
    new_req(0, $urandom_range(0, 2)); new_req(1, $urandom_range(0, 2));
    run_idle(200);
    new_req(0, $urandom_range(0, 2)); new_req(1, $urandom_range(0, 2));
    run_idle(200);
    chk("t2_count", gseq.size(), 4);
    gv = '0;
    foreach (gseq[i]) if (i < 4) gv[3-i] = gseq[i];
    chk("t2_gseq", gv, 4'b0101);

    // m1 arlen=3 with rready toggling
    beats_to[1] = 0; force_sl = 1'b1; toggle_rr = 1'b1;
    new_req(1, 3);
    run_idle(100);
    chk("t4_beats", beats_to[1], 4);
    chk("t4_err_last", err_last, 0);
    force_sl = 1'b0; toggle_rr = 1'b0;

    // random traffic
    n0 = gseq.size();
    reqs_left[0] = 25; reqs_left[1] = 25;
    run_idle(6000);
    chk("rand_grants", gseq.size() - n0, 50);

    // early rlast on beat 2 of arlen=3
    beats_to[1] = 0; inj_early = 1'b1;
    new_req(1, 3);
    run_idle(200);
    for (int i = 0; i < 3; i++) step();
    chk("t5_err_sticky", err_last, 1);
    chk("t5_beats", beats_to[1], 2);
    chk("t5_state", dut_state, ARB_IDLE);

    // reset during DATA beat 1, then a fresh m0 read
    new_req(0, 3);
    c = 0;
    while (!(ph == PH_DATA && beat_k >= 1) && c < 300) begin
      step();
      c++;
    end
    chk("t6_reach_data", c < 300, 1);
    do_reset();
    #1;
    chk_reset_outputs();
    @(posedge clk); #1;
    new_req(0, 1);
    run_idle(100);
    chk("t6_grants", gseq.size(), 1);
    chk("t6_beats", beats_to[0], 2);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_rd_arb.md
# axi_rd_arb

Two-master AXI4 read-channel arbiter that shares the single instruction ROM read port (AXI_ROM slave) between the RVSEED IFU (master 0) and a second read master (master 1, load/debug path). It sits at the top level between the masters and the ROM slave. It grants one transaction at a time, by round-robin or fixed priority. The grant is locked from AR issue until the final R beat, and R beats are routed back to the granted master.

## Interface
- RR_EN, default 1: 1 = round-robin between masters; 0 = fixed priority, master 0 wins.
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- mN_arvalid / mN_arready  in / out  1  AR handshake, master N (N = 0, 1).
- mN_ar{id,addr,len,size,burst,lock,cache,prot,qos,region}  in  AXI_*_WIDTH  AR payload, master N.
- mN_rvalid / mN_rready  out / in  1  R handshake, master N.
- mN_r{id,data,resp,last}  out  AXI_*_WIDTH  R payload to master N.
- s_arvalid / s_arready  out / in  1  AR handshake to the ROM slave.
- s_ar{id,...,region}  out  AXI_*_WIDTH  muxed AR payload; arid is passed unchanged.
- s_rvalid / s_rready  in / out  1  R handshake from the slave.
- s_r{id,data,resp,last}  in  AXI_*_WIDTH  R payload from the slave.
- grant_id  out  1  index of the currently or most recently granted master.
- err_last  out  1  sticky: the rlast position disagreed with the granted arlen.

## Operation
- FSM states:
  - IDLE: no grant.
  - ADDR: s_arvalid=1; wait for s_arready.
  - DATA: forward R beats until the rlast handshake.
- IDLE -> ADDR when any mN_arvalid is high.
  - Winner = the requester if only one is valid.
  - If both are valid: winner = the master pointed to by prio_ptr (RR_EN=1), or master 0 (RR_EN=0).
  - The winner is registered in grant_id.
- ADDR:
  - s_ar* = payload of the granted master; s_arvalid=1.
  - m[grant]_arready = s_arready; the other master's arready = 0.
  - On s_arvalid&s_arready: capture arlen into beat_rem, then go to DATA.
- DATA:
  - m[grant]_rvalid = s_rvalid; s_rready = m[grant]_rready; m[grant]_r* = s_r*.
  - The non-granted master sees rvalid=0; its r* outputs are don't-care (driven 0).
  - On each beat handshake, beat_rem decrements.
  - On a handshake with s_rlast=1: go to IDLE; if RR_EN=1, prio_ptr = ~grant_id.
  - err_last is set when rlast=1 with beat_rem!=0, or rlast=0 with beat_rem==0.
  - err_last clears only on reset.
- A request from the non-granted master is held off (arready=0) until the FSM returns to IDLE. No request is dropped.
- Only one outstanding transaction at a time. No AR pipelining.
- beat_rem is AXI_LEN_WIDTH wide and does not wrap below 0. At 0 it holds 0 and flags the error.
- Reset (at any point, including mid-burst):
  - state=IDLE, grant_id=0, prio_ptr=0, beat_rem=0, err_last=0.
  - All valid/ready outputs = 0.
  - An in-flight slave burst is abandoned; the slave is reset by the same rst_n.

## Timing
- Arbitration latency: mN_arvalid rising in IDLE at cycle T gives s_arvalid=1 at T+1.
- AR and R paths are combinational through the mux in ADDR/DATA, with zero added latency per beat.
- Valid and payload outputs depend only on registered state and the granted master's inputs, so AXI stability holds while the master holds valid.
- The rlast handshake at cycle T gives IDLE at T+1. A pending request is re-arbitrated at T+1, giving s_arvalid at T+2.
- Minimum gap between back-to-back transactions: 1 idle cycle.

## Structure
- Shared AXI define header: AXI_*_WIDTH constants (existing), plus state encodings ARB_IDLE=2'd0, ARB_ADDR=2'd1, ARB_DATA=2'd2.
- Sub-module rr_arb2: 2-way round-robin picker.
  - Inputs: req[1:0], prio_ptr, rr_en.
  - Output: one-hot gnt.
  - The pointer update stays in axi_rd_arb.

## Test plan
- Master 0 only, araddr=0x100, arlen=0 → s_arvalid at T+1, single beat routed to m0, m1_rvalid stays 0, back in IDLE after rlast.
- Both masters request at the same cycle after reset, RR_EN=1 → m0 is granted first, m1 next; a second simultaneous pair grants m0 then m1 again; grant_id sequence 0,1,0,1.
- RR_EN=0, both request continuously → m0 is always granted, m1 starves; m1_arready is never 1.
- m1 burst arlen=3 with rready toggled 1,0,1,0 → exactly 4 beats delivered, data in order; s_rready mirrors m1_rready; err_last=0.
- Slave asserts rlast on beat 2 of an arlen=3 burst → err_last=1 and stays 1; FSM returns to IDLE.
- rst_n pulsed low during DATA beat 1 → next cycle all outputs are 0, state IDLE, err_last=0, and a new m0 request is granted normally.
